// File: rtl/song_loader.sv
// Song SRAM writer: assembles byte pairs into 16-bit words and writes them from BASE_ADDR up to the END word.
// Optional trailing XOR checksum byte is enabled by defining SONG_LOADER_CHECKSUM_EN.
module song_loader #(
    parameter logic [17:0] BASE_ADDR = 18'hff00,
    parameter int          MAX_WORDS = 256,
    parameter int          WE_CYCLES = 3
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        START,
    input  logic [7:0]  RX_DATA,
    input  logic        RX_VALID,
    output logic        RX_READY,
    output logic        SRAM_CE,
    output logic        SRAM_LB,
    output logic        SRAM_UB,
    output logic        SRAM_OE,
    output logic        SRAM_WE,
    output logic [17:0] SRAM_A,
    output logic [15:0] SRAM_DQ_OUT,
    output logic        SRAM_DQ_OE,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR,
    output logic [17:0] WORD_COUNT
);

    localparam int              WE_CNT_W  = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;
    localparam logic [WE_CNT_W-1:0] WE_LAST = WE_CNT_W'(WE_CYCLES - 1);
    localparam logic [17:0]     MAX_COUNT = 18'(MAX_WORDS);

    typedef enum logic [3:0] {
        IDLE,
        HI,
        LO,
        SETUP,
        WRITE,
        HOLD,
`ifdef SONG_LOADER_CHECKSUM_EN
        CHECK,
`endif
        FIN,
        FAIL
    } state_t;

    state_t              state;
    state_t              stateNext;
    logic [15:0]         wordReg;
    logic [17:0]         wordCount;
    logic [WE_CNT_W-1:0] weCnt;
    logic                accept;
`ifdef SONG_LOADER_CHECKSUM_EN
    logic [7:0]          csum;
`endif

    function automatic logic isEnd(input logic [15:0] w);
        return w[15:12] == 4'b0000;
    endfunction

    assign accept = RX_VALID && RX_READY;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext  = state;
        RX_READY   = 1'b0;
        SRAM_WE    = 1'b1;
        SRAM_DQ_OE = 1'b0;
        BUSY       = 1'b0;
        case (state)
            IDLE, FIN, FAIL: begin
                if (START) begin
                    stateNext = HI;
                end
            end
            HI: begin
                RX_READY = 1'b1;
                BUSY     = 1'b1;
                if (accept) begin
                    stateNext = LO;
                end
            end
            LO: begin
                RX_READY = 1'b1;
                BUSY     = 1'b1;
                // A full song area rejects the extra word before any write starts
                if (accept) begin
                    stateNext = (wordCount == MAX_COUNT) ? FAIL : SETUP;
                end
            end
            SETUP: begin
                BUSY       = 1'b1;
                SRAM_DQ_OE = 1'b1;
                stateNext  = WRITE;
            end
            WRITE: begin
                BUSY       = 1'b1;
                SRAM_DQ_OE = 1'b1;
                SRAM_WE    = 1'b0;
                if (weCnt == WE_LAST) begin
                    stateNext = HOLD;
                end
            end
            HOLD: begin
                BUSY       = 1'b1;
                SRAM_DQ_OE = 1'b1;
                if (isEnd(wordReg)) begin
`ifdef SONG_LOADER_CHECKSUM_EN
                    stateNext = CHECK;
`else
                    stateNext = FIN;
`endif
                end else begin
                    stateNext = HI;
                end
            end
`ifdef SONG_LOADER_CHECKSUM_EN
            CHECK: begin
                RX_READY = 1'b1;
                BUSY     = 1'b1;
                if (accept) begin
                    stateNext = (RX_DATA == csum) ? FIN : FAIL;
                end
            end
`endif
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            wordReg   <= 16'h0000;
            wordCount <= 18'd0;
            weCnt     <= '0;
`ifdef SONG_LOADER_CHECKSUM_EN
            csum      <= 8'h00;
`endif
        end else begin
            case (state)
                IDLE, FIN, FAIL: begin
                    if (START) begin
                        wordCount <= 18'd0;
`ifdef SONG_LOADER_CHECKSUM_EN
                        csum      <= 8'h00;
`endif
                    end
                end
                HI: begin
                    if (accept) begin
                        wordReg[15:8] <= RX_DATA;
`ifdef SONG_LOADER_CHECKSUM_EN
                        csum          <= csum ^ RX_DATA;
`endif
                    end
                end
                LO: begin
                    if (accept) begin
                        wordReg[7:0] <= RX_DATA;
`ifdef SONG_LOADER_CHECKSUM_EN
                        csum         <= csum ^ RX_DATA;
`endif
                    end
                end
                SETUP: begin
                    weCnt <= '0;
                end
                WRITE: begin
                    weCnt <= weCnt + 1'b1;
                end
                HOLD: begin
                    // Count only after the strobe has fully completed
                    wordCount <= wordCount + 18'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // DONE/ERR are sticky simply because FIN/FAIL are held until the next START
    assign DONE        = (state == FIN);
    assign ERR         = (state == FAIL);
    assign SRAM_OE     = BUSY;
    assign SRAM_CE     = 1'b0;
    assign SRAM_LB     = 1'b0;
    assign SRAM_UB     = 1'b0;
    assign SRAM_A      = BASE_ADDR + wordCount;
    assign SRAM_DQ_OUT = wordReg;
    assign WORD_COUNT  = wordCount;

endmodule

// File: tb/tb_song_loader.sv
// Scoreboard bench for song_loader: a stimulus process queues expected SRAM writes, a monitor checks each strobe.
module tb_song_loader;

    localparam logic [17:0] BASE = 18'h3ff00;
    localparam int          MAXW = 4;
    localparam int          WEC  = 3;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        START = 1'b0;
    logic [7:0]  RX_DATA = 8'h00;
    logic        RX_VALID = 1'b0;
    logic        RX_READY;
    logic        SRAM_CE, SRAM_LB, SRAM_UB, SRAM_OE, SRAM_WE;
    logic [17:0] SRAM_A;
    logic [15:0] SRAM_DQ_OUT;
    logic        SRAM_DQ_OE, BUSY, DONE, ERR;
    logic [17:0] WORD_COUNT;

    song_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW), .WE_CYCLES(WEC)) dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
        .RX_READY(RX_READY), .SRAM_CE(SRAM_CE), .SRAM_LB(SRAM_LB), .SRAM_UB(SRAM_UB),
        .SRAM_OE(SRAM_OE), .SRAM_WE(SRAM_WE), .SRAM_A(SRAM_A), .SRAM_DQ_OUT(SRAM_DQ_OUT),
        .SRAM_DQ_OE(SRAM_DQ_OE), .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .WORD_COUNT(WORD_COUNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [17:0] a;
        logic [15:0] d;
    } wr_t;

    wr_t expQ[$];
    int  checks = 0;
    int  errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: one comparison set per completed SRAM write strobe
    logic        inWr = 1'b0;
    logic [17:0] capA, prevA;
    logic [15:0] capD, prevD;
    logic        prevOe = 1'b0;
    logic        setupOk, stableOk, holdOk;
    int          lowCnt;
    wr_t         e;

    always @(negedge CLK) begin
        if (!RST_N) begin
            inWr = 1'b0;
        end else if (!SRAM_WE && !inWr) begin
            inWr     = 1'b1;
            capA     = SRAM_A;
            capD     = SRAM_DQ_OUT;
            lowCnt   = 1;
            setupOk  = prevOe && (prevA == SRAM_A) && (prevD == SRAM_DQ_OUT);
            stableOk = SRAM_DQ_OE;
        end else if (!SRAM_WE) begin
            lowCnt++;
            if (SRAM_A != capA || SRAM_DQ_OUT != capD || !SRAM_DQ_OE) stableOk = 1'b0;
        end else if (inWr) begin
            inWr   = 1'b0;
            holdOk = SRAM_DQ_OE && (SRAM_A == capA) && (SRAM_DQ_OUT == capD);
            check("we_low_cycles", 32'(lowCnt), 32'(WEC));
            check("setup_stable_hold", {29'd0, setupOk, stableOk, holdOk}, 32'h7);
            check("ctrl_pins", {28'd0, SRAM_OE, SRAM_CE, SRAM_LB, SRAM_UB}, 32'h8);
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual=%0h@%0h required=none", capD, capA);
            end else begin
                e = expQ.pop_front();
                check("write_addr", 32'(capA), 32'(e.a));
                check("write_data", 32'(capD), 32'(e.d));
            end
        end
        prevA  = SRAM_A;
        prevD  = SRAM_DQ_OUT;
        prevOe = SRAM_DQ_OE;
    end

    task automatic startLoad();
        @(negedge CLK);
        START = 1'b1;
        @(posedge CLK);
        #1 START = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] b, output int waitCnt, output bit ok);
        @(negedge CLK);
        START    = 1'b0;
        RX_DATA  = b;
        RX_VALID = 1'b1;
        waitCnt  = 0;
        while (!RX_READY && waitCnt < 100) begin
            @(negedge CLK);
            waitCnt++;
        end
        ok = RX_READY;
        if (ok) @(posedge CLK);
    endtask

    task automatic gapCycles(input int g, input bit strayStart);
        repeat (g) begin
            @(negedge CLK);
            RX_VALID = 1'b0;
            START    = strayStart && ($urandom_range(0, 3) == 0);
        end
    endtask

    task automatic waitIdle();
        int n = 0;
        @(negedge CLK);
        RX_VALID = 1'b0;
        while (BUSY && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (BUSY) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout actual=1 required=0");
        end
    endtask

    task automatic sendTracked(input logic [7:0] b, input int g, input bit prevLow, input bit strayStart,
                               output bit ok);
        int w;
        int req;
        gapCycles(g, strayStart);
        sendByte(b, w, ok);
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL rx_ready_timeout actual=0 required=1");
            return;
        end
        req = prevLow ? (((WEC + 2 - g) > 0) ? (WEC + 2 - g) : 0) : 0;
        check("rx_ready_wait", 32'(w), 32'(req));
    endtask

    // Reference model: which words land where, and how the load ends
    task automatic runSong(input logic [15:0] words[$], input bit randGaps, input bit badSum);
        bit          expDone = 1'b0;
        bit          expErr  = 1'b0;
        int          expCnt  = 0;
        int          nSend   = 0;
        logic [7:0]  sum     = 8'h00;
        bit          ok;
        bit          prevLow = 1'b0;
        for (int i = 0; i < words.size(); i++) begin
            nSend = i + 1;
            sum   = sum ^ words[i][15:8] ^ words[i][7:0];
            if (i >= MAXW) begin
                expErr = 1'b1;
                break;
            end
            expQ.push_back('{a: BASE + 18'(i), d: words[i]});
            expCnt = i + 1;
            if (words[i][15:12] == 4'h0) begin
                expDone = 1'b1;
                break;
            end
        end
        startLoad();
        for (int i = 0; i < nSend; i++) begin
            for (int h = 0; h < 2; h++) begin
                int g = randGaps ? int'($urandom_range(0, 6)) : 0;
                sendTracked(h == 0 ? words[i][15:8] : words[i][7:0], g, prevLow, randGaps, ok);
                if (!ok) return;
                prevLow = (h == 1);
            end
        end
`ifdef SONG_LOADER_CHECKSUM_EN
        if (expDone) begin
            int g = randGaps ? int'($urandom_range(0, 6)) : 0;
            sendTracked(badSum ? (sum ^ 8'h5a) : sum, g, 1'b1, randGaps, ok);
            if (!ok) return;
            expDone = !badSum;
            expErr  = badSum;
        end
`else
        if (badSum) expErr = expErr;
`endif
        waitIdle();
        check("done", 32'(DONE), 32'(expDone));
        check("err", 32'(ERR), 32'(expErr));
        check("word_count", 32'(WORD_COUNT), 32'(expCnt));
        check("writes_outstanding", 32'(expQ.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] song[$];
        bit          ok;
        int          n;
        logic [15:0] w;

        RST_N = 1'b0;
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;

        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            check("idle_ctrl", {25'd0, RX_READY, SRAM_WE, SRAM_OE, SRAM_DQ_OE, BUSY, DONE, ERR}, 32'h20);
            if (i == 0) begin
                check("idle_addr", 32'(SRAM_A), 32'(BASE));
                check("idle_data_count", {SRAM_DQ_OUT, 14'd0, WORD_COUNT[1:0]}, 32'd0);
            end
        end

        song = '{16'h8a21, 16'h1060, 16'h0000};
        runSong(song, 1'b0, 1'b0);

        song = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
        runSong(song, 1'b0, 1'b0);

`ifdef SONG_LOADER_CHECKSUM_EN
        song = '{16'h8001, 16'h0000};
        runSong(song, 1'b0, 1'b0);
        runSong(song, 1'b0, 1'b1);
`endif

        for (int s = 0; s < 10; s++) begin
            song.delete();
            n = $urandom_range(1, MAXW + 1);
            for (int i = 0; i < n; i++) begin
                w = 16'($urandom);
                if (i == MAXW)       w[15:12] = 4'($urandom_range(0, 15));
                else if (i == n - 1) w[15:12] = 4'h0;
                else                 w[15:12] = 4'($urandom_range(1, 15));
                song.push_back(w);
            end
            runSong(song, 1'b1, ($urandom_range(0, 1) == 1));
        end

        // Reset in the second WRITE cycle of the second word
        startLoad();
        expQ.push_back('{a: BASE, d: 16'h9123});
        sendTracked(8'h91, 0, 1'b0, 1'b0, ok);
        sendTracked(8'h23, 0, 1'b0, 1'b0, ok);
        sendTracked(8'h45, 0, 1'b1, 1'b0, ok);
        sendTracked(8'h67, 0, 1'b0, 1'b0, ok);
        @(negedge CLK);
        RX_VALID = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        check("pre_reset_we_count", {13'd0, SRAM_WE, WORD_COUNT}, 32'd1);
        RST_N = 1'b0;
        @(negedge CLK);
        check("reset_ctrl", {26'd0, SRAM_WE, SRAM_DQ_OE, BUSY, RX_READY, DONE, ERR}, 32'h20);
        check("reset_count", 32'(WORD_COUNT), 32'd0);
        check("reset_addr", 32'(SRAM_A), 32'(BASE));
        @(negedge CLK);
        RST_N = 1'b1;
        check("reset_queue_left", 32'(expQ.size()), 32'd0);

        song = '{16'hc0de, 16'h0bad};
        runSong(song, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
